idex_stage_reg: RTL and testbench
=================================

Name: idex_stage_reg

Overview:
Parametrised ID/EX pipeline register with stall (hold), flush (bubble insertion) and built-in load-use hazard detection. Sits between decode and execute. Captures decoded control, operand data, immediate, PC and register addresses. Adds a valid bit and saturating stall/bubble counters for performance visibility.

Parameters:
DATA_W, 32, width of RSdata, RTdata, Sign_Extend
ADDR_W, 32, width of instruction address
REG_AW, 5, register address width
CTRL_W, 9, packed control width; map [8]RegWrite [7]MemtoReg [6]Branch [5]MemRead [4]MemWrite [3]RegDst [2]ALUSrc [1:0]ALUOp
CNT_W, 16, perf counter width
HAZARD_EN, 1, 1 = load-use detection active; 0 = hazard_o tied 0

Ports:
clk_i  in  1  clock, all state on rising edge
start_i  in  1  asynchronous active-low reset
stall_i  in  1  hold all registers this cycle
flush_i  in  1  load a bubble this cycle
ctrl_i  in  CTRL_W  decoded control from ID
addr_i  in  ADDR_W  instruction address
RSdata_i, RTdata_i  in  DATA_W  register file read data
Sign_Extend_i  in  DATA_W  sign-extended immediate
RSaddr_i, RTaddr_i, RDaddr_i  in  REG_AW  instr[25:21], [20:16], [15:11]
ctrl_o  out  CTRL_W  registered control (zero when bubble)
addr_o  out  ADDR_W
RSdata_o, RTdata_o, Sign_Extend_o  out  DATA_W
RSaddr_o, RTaddr_o, RDaddr_o  out  REG_AW
valid_o  out  1  stage holds a real instruction
hazard_o  out  1  combinational load-use hazard; ID/IF must hold when high
stall_cnt_o  out  CNT_W  cycles held by stall_i
bubble_cnt_o  out  CNT_W  bubbles inserted (flush or hazard)

Behaviour:
- Reset (start_i low, async): every output register 0, valid_o 0, both counters 0. Holds while start_i low regardless of clock.
- hazard_o = HAZARD_EN & valid_o & ctrl_o[5] & (RTaddr_o != 0) & (RTaddr_o == RSaddr_i | RTaddr_o == RTaddr_i). Purely combinational from current state + ID addresses.
- Per-edge action, strict priority:
  1. flush_i=1: LOAD_BUBBLE.
  2. stall_i=1: HOLD; all outputs unchanged.
  3. hazard_o=1: LOAD_BUBBLE.
  4. else: LOAD; all _o <= _i, valid_o <= 1.
- LOAD_BUBBLE: ctrl_o <= 0, valid_o <= 0; data, address and register-address fields still load from inputs; no architectural effect since control is 0.
- Latency: 1 cycle input to output on LOAD.
- A bubble clears hazard_o on the next cycle, because valid_o=0. Exactly one bubble is inserted per load-use pair.
- stall_i with hazard_o: HOLD wins; the hazard persists and resolves after the stall releases.
- stall_cnt_o +1 on each HOLD edge. bubble_cnt_o +1 on each LOAD_BUBBLE edge. Both saturate at 2^CNT_W-1 with no wrap.
- flush_i during stall_i: bubble loaded, stall_cnt_o not incremented.
- Reset mid-operation: immediate clear. First edge after release performs normal action per priority.

Test Plan:
1. Reset then LOAD: start_i 0->1, ctrl_i=9'h1A4, RSdata_i=32'hDEADBEEF, addr_i=32'h40 -> after 1 edge ctrl_o=9'h1A4, RSdata_o=32'hDEADBEEF, addr_o=32'h40, valid_o=1; reset again -> all outputs 0 immediately without clock.
2. Load-use: EX holds lw with ctrl_o[5]=1, RTaddr_o=8; ID presents RSaddr_i=8 -> hazard_o=1; next edge ctrl_o=0, valid_o=0, bubble_cnt_o=1, hazard_o=0; following edge loads ID instruction normally.
3. No false hazard: RTaddr_o=0 with MemRead, ID RSaddr_i=0 -> hazard_o=0. HAZARD_EN=0 with matching addresses -> hazard_o=0.
4. Stall: stall_i high 3 cycles with changing inputs -> outputs frozen, stall_cnt_o=3, bubble_cnt_o unchanged. Stall together with an active hazard -> hold, hazard_o stays 1.
5. Flush priority: flush_i=1 and stall_i=1 same edge -> ctrl_o=0, valid_o=0, bubble_cnt_o+1, stall_cnt_o unchanged.
6. Saturation with CNT_W=2: 5 consecutive stalls -> stall_cnt_o=3 and remains 3.

Source files
------------

// File: rtl/idex_stage_reg_if.sv
// ---------------------------------------------------------------------------
// Module : idex_stage_reg_if
// Brief  : ID-side inputs and EX-side outputs of the ID/EX pipeline register.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface idex_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 9,
    parameter int CNT_W  = 16
) ();
    logic              stall_i;
    logic              flush_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] RSdata_i;
    logic [DATA_W-1:0] RTdata_i;
    logic [DATA_W-1:0] Sign_Extend_i;
    logic [REG_AW-1:0] RSaddr_i;
    logic [REG_AW-1:0] RTaddr_i;
    logic [REG_AW-1:0] RDaddr_i;

    logic [CTRL_W-1:0] ctrl_o;
    logic [ADDR_W-1:0] addr_o;
    logic [DATA_W-1:0] RSdata_o;
    logic [DATA_W-1:0] RTdata_o;
    logic [DATA_W-1:0] Sign_Extend_o;
    logic [REG_AW-1:0] RSaddr_o;
    logic [REG_AW-1:0] RTaddr_o;
    logic [REG_AW-1:0] RDaddr_o;
    logic              valid_o;
    logic              hazard_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  bubble_cnt_o;

    modport slave (
        input  stall_i, flush_i, ctrl_i, addr_i, RSdata_i, RTdata_i,
               Sign_Extend_i, RSaddr_i, RTaddr_i, RDaddr_i,
        output ctrl_o, addr_o, RSdata_o, RTdata_o, Sign_Extend_o,
               RSaddr_o, RTaddr_o, RDaddr_o, valid_o, hazard_o,
               stall_cnt_o, bubble_cnt_o
    );

    modport master (
        output stall_i, flush_i, ctrl_i, addr_i, RSdata_i, RTdata_i,
               Sign_Extend_i, RSaddr_i, RTaddr_i, RDaddr_i,
        input  ctrl_o, addr_o, RSdata_o, RTdata_o, Sign_Extend_o,
               RSaddr_o, RTaddr_o, RDaddr_o, valid_o, hazard_o,
               stall_cnt_o, bubble_cnt_o
    );
endinterface

`default_nettype wire

// File: rtl/idex_stage_reg.sv
// ---------------------------------------------------------------------------
// Module : idex_stage_reg
// Brief  : ID/EX pipeline register with stall, flush, load-use bubble and
//          saturating stall/bubble counters.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module idex_stage_reg #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int REG_AW    = 5,
    parameter int CTRL_W    = 9,
    parameter int CNT_W     = 16,
    parameter bit HAZARD_EN = 1'b1
) (
    input  wire logic          clk_i,
    input  wire logic          start_i,
    idex_stage_reg_if.slave    bus
);
    localparam logic [1:0]       C_ACT_LOAD   = 2'd0;
    localparam logic [1:0]       C_ACT_HOLD   = 2'd1;
    localparam logic [1:0]       C_ACT_BUBBLE = 2'd2;
    localparam logic [CNT_W-1:0] C_CNT_MAX    = '1;

    logic [CTRL_W-1:0] r_ctrl;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_sign_ext;
    logic [REG_AW-1:0] r_rs_addr;
    logic [REG_AW-1:0] r_rt_addr;
    logic [REG_AW-1:0] r_rd_addr;
    logic              r_valid;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic              w_hazard;
    logic [1:0]        w_act;

    // Load-use: a valid load in EX whose destination is a source of the ID instruction.
    generate
        if (HAZARD_EN) begin : g_hazard
            assign w_hazard = r_valid && r_ctrl[5] && (r_rt_addr != '0) &&
                              ((r_rt_addr == bus.RSaddr_i) || (r_rt_addr == bus.RTaddr_i));
        end else begin : g_no_hazard
            assign w_hazard = 1'b0;
        end
    endgenerate

    always_comb begin
        w_act = C_ACT_LOAD;
        if (bus.flush_i)
            w_act = C_ACT_BUBBLE;
        else if (bus.stall_i)
            w_act = C_ACT_HOLD;
        else if (w_hazard)
            w_act = C_ACT_BUBBLE;
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            r_ctrl       <= '0;
            r_addr       <= '0;
            r_rs_data    <= '0;
            r_rt_data    <= '0;
            r_sign_ext   <= '0;
            r_rs_addr    <= '0;
            r_rt_addr    <= '0;
            r_rd_addr    <= '0;
            r_valid      <= 1'b0;
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            // Bubbles still capture the datapath fields; zero control makes them inert.
            if (w_act != C_ACT_HOLD) begin
                r_addr     <= bus.addr_i;
                r_rs_data  <= bus.RSdata_i;
                r_rt_data  <= bus.RTdata_i;
                r_sign_ext <= bus.Sign_Extend_i;
                r_rs_addr  <= bus.RSaddr_i;
                r_rt_addr  <= bus.RTaddr_i;
                r_rd_addr  <= bus.RDaddr_i;
            end
            case (w_act)
                C_ACT_BUBBLE: begin
                    r_ctrl  <= '0;
                    r_valid <= 1'b0;
                    if (r_bubble_cnt != C_CNT_MAX)
                        r_bubble_cnt <= r_bubble_cnt + 1'b1;
                end
                C_ACT_HOLD: begin
                    if (r_stall_cnt != C_CNT_MAX)
                        r_stall_cnt <= r_stall_cnt + 1'b1;
                end
                default: begin
                    r_ctrl  <= bus.ctrl_i;
                    r_valid <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ctrl_o        = r_ctrl;
    assign bus.addr_o        = r_addr;
    assign bus.RSdata_o      = r_rs_data;
    assign bus.RTdata_o      = r_rt_data;
    assign bus.Sign_Extend_o = r_sign_ext;
    assign bus.RSaddr_o      = r_rs_addr;
    assign bus.RTaddr_o      = r_rt_addr;
    assign bus.RDaddr_o      = r_rd_addr;
    assign bus.valid_o       = r_valid;
    assign bus.hazard_o      = w_hazard;
    assign bus.stall_cnt_o   = r_stall_cnt;
    assign bus.bubble_cnt_o  = r_bubble_cnt;

endmodule

`default_nettype wire

// File: tb/tb_idex_stage_reg.sv
// ---------------------------------------------------------------------------
// Module : tb_idex_stage_reg
// Brief  : Self-checking bench; DUT A uses defaults, DUT B has CNT_W=2 and
//          hazard detection disabled. Both track their own reference models.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_idex_stage_reg;
    typedef struct {
        logic       st, fl;
        logic [8:0] c;
        logic [31:0] a, rsd, rtd, se;
        logic [4:0] rs, rt, rd;
    } in_t;

    typedef struct {
        logic [8:0]  ctrl;
        logic [31:0] addr, rsd, rtd, se;
        logic [4:0]  rsa, rta, rda;
        logic        valid;
        int          scnt, bcnt;
    } ms_t;

    logic clk = 1'b0;
    logic start_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    ms_t  ma, mb, zero_m;

    always #5 clk = ~clk;

    idex_stage_reg_if #(.CNT_W(16)) ifa ();
    idex_stage_reg_if #(.CNT_W(2))  ifb ();

    idex_stage_reg #(.CNT_W(16), .HAZARD_EN(1'b1)) dut_a (.clk_i(clk), .start_i(start_n), .bus(ifa));
    idex_stage_reg #(.CNT_W(2),  .HAZARD_EN(1'b0)) dut_b (.clk_i(clk), .start_i(start_n), .bus(ifb));

    assign ifb.stall_i       = ifa.stall_i;
    assign ifb.flush_i       = ifa.flush_i;
    assign ifb.ctrl_i        = ifa.ctrl_i;
    assign ifb.addr_i        = ifa.addr_i;
    assign ifb.RSdata_i      = ifa.RSdata_i;
    assign ifb.RTdata_i      = ifa.RTdata_i;
    assign ifb.Sign_Extend_i = ifa.Sign_Extend_i;
    assign ifb.RSaddr_i      = ifa.RSaddr_i;
    assign ifb.RTaddr_i      = ifa.RTaddr_i;
    assign ifb.RDaddr_i      = ifa.RDaddr_i;

    function automatic logic hz(ms_t s, logic [4:0] rs, logic [4:0] rt, bit en);
        return en && s.valid && s.ctrl[5] && (s.rta != 5'd0) && (s.rta == rs || s.rta == rt);
    endfunction

    function automatic ms_t nxt(ms_t s, in_t i, bit en, int maxc);
        ms_t n = s;
        bit bubble = i.fl || (!i.st && hz(s, i.rs, i.rt, en));
        if (i.st && !i.fl) begin
            n.scnt = (s.scnt < maxc) ? s.scnt + 1 : maxc;
            return n;
        end
        n.addr = i.a; n.rsd = i.rsd; n.rtd = i.rtd; n.se = i.se;
        n.rsa = i.rs; n.rta = i.rt; n.rda = i.rd;
        if (bubble) begin
            n.ctrl = 9'd0; n.valid = 1'b0;
            n.bcnt = (s.bcnt < maxc) ? s.bcnt + 1 : maxc;
        end else begin
            n.ctrl = i.c; n.valid = 1'b1;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ":A.ctrl"},  64'(ifa.ctrl_o),        64'(ma.ctrl));
        chk({tag, ":A.valid"}, 64'(ifa.valid_o),       64'(ma.valid));
        chk({tag, ":A.addr"},  64'(ifa.addr_o),        64'(ma.addr));
        chk({tag, ":A.rsd"},   64'(ifa.RSdata_o),      64'(ma.rsd));
        chk({tag, ":A.rtd"},   64'(ifa.RTdata_o),      64'(ma.rtd));
        chk({tag, ":A.se"},    64'(ifa.Sign_Extend_o), 64'(ma.se));
        chk({tag, ":A.regs"},  64'({ifa.RSaddr_o, ifa.RTaddr_o, ifa.RDaddr_o}),
                               64'({ma.rsa, ma.rta, ma.rda}));
        chk({tag, ":A.scnt"},  64'(ifa.stall_cnt_o),   64'(ma.scnt));
        chk({tag, ":A.bcnt"},  64'(ifa.bubble_cnt_o),  64'(ma.bcnt));
        chk({tag, ":A.haz"},   64'(ifa.hazard_o),      64'(hz(ma, ifa.RSaddr_i, ifa.RTaddr_i, 1'b1)));
        chk({tag, ":B.ctrl"},  64'(ifb.ctrl_o),        64'(mb.ctrl));
        chk({tag, ":B.valid"}, 64'(ifb.valid_o),       64'(mb.valid));
        chk({tag, ":B.scnt"},  64'(ifb.stall_cnt_o),   64'(mb.scnt));
        chk({tag, ":B.bcnt"},  64'(ifb.bubble_cnt_o),  64'(mb.bcnt));
        chk({tag, ":B.haz"},   64'(ifb.hazard_o),      64'd0);
    endtask

    // Drive one instruction, check the pre-edge hazard, clock it, check the result.
    task automatic step(input in_t i, input string tag);
        ifa.stall_i = i.st; ifa.flush_i = i.fl; ifa.ctrl_i = i.c; ifa.addr_i = i.a;
        ifa.RSdata_i = i.rsd; ifa.RTdata_i = i.rtd; ifa.Sign_Extend_i = i.se;
        ifa.RSaddr_i = i.rs; ifa.RTaddr_i = i.rt; ifa.RDaddr_i = i.rd;
        #1;
        chk({tag, ":preA.haz"}, 64'(ifa.hazard_o), 64'(hz(ma, i.rs, i.rt, 1'b1)));
        @(posedge clk);
        ma = nxt(ma, i, 1'b1, 65535);
        mb = nxt(mb, i, 1'b0, 3);
        #1;
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        #2 start_n = 1'b0;
        #1;
        ma = zero_m; mb = zero_m;
        check_state(tag);
        @(negedge clk) start_n = 1'b1;
    endtask

    function automatic in_t mk(bit st, bit fl, logic [8:0] c, logic [31:0] a,
                               logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
        in_t i;
        i.st = st; i.fl = fl; i.c = c; i.a = a;
        i.rsd = $urandom; i.rtd = $urandom; i.se = $urandom;
        i.rs = rs; i.rt = rt; i.rd = rd;
        return i;
    endfunction

    initial begin
        in_t i;
        zero_m = '{ctrl: '0, addr: '0, rsd: '0, rtd: '0, se: '0, rsa: '0, rta: '0,
                   rda: '0, valid: 1'b0, scnt: 0, bcnt: 0};
        ma = zero_m; mb = zero_m;
        ifa.stall_i = 0; ifa.flush_i = 0; ifa.ctrl_i = 0; ifa.addr_i = 0;
        ifa.RSdata_i = 0; ifa.RTdata_i = 0; ifa.Sign_Extend_i = 0;
        ifa.RSaddr_i = 0; ifa.RTaddr_i = 0; ifa.RDaddr_i = 0;
        repeat (2) @(posedge clk);
        #1 check_state("reset");
        start_n = 1'b1;

        // Reset then LOAD, then asynchronous re-reset
        i = mk(0, 0, 9'h1A4, 32'h40, 5'd1, 5'd2, 5'd3);
        i.rsd = 32'hDEADBEEF;
        step(i, "t1_load");
        chk("t1_ctrl", 64'(ifa.ctrl_o), 64'h1A4);
        chk("t1_rsd", 64'(ifa.RSdata_o), 64'hDEADBEEF);
        chk("t1_addr", 64'(ifa.addr_o), 64'h40);
        chk("t1_valid", 64'(ifa.valid_o), 64'd1);
        do_reset("t1_rst");

        // Load-use: lw writes r8, next instruction reads r8
        step(mk(0, 0, 9'h1A0, 32'h100, 5'd1, 5'd8, 5'd0), "t2_lw");
        i = mk(0, 0, 9'h10C, 32'h104, 5'd8, 5'd9, 5'd10);
        step(i, "t2_bubble");
        chk("t2_ctrl0", 64'(ifa.ctrl_o), 64'd0);
        chk("t2_valid0", 64'(ifa.valid_o), 64'd0);
        chk("t2_bcnt1", 64'(ifa.bubble_cnt_o), 64'd1);
        chk("t2_haz0", 64'(ifa.hazard_o), 64'd0);
        step(i, "t2_reload");
        chk("t2_ctrl", 64'(ifa.ctrl_o), 64'h10C);
        chk("t2_valid", 64'(ifa.valid_o), 64'd1);

        // No false hazard on r0
        step(mk(0, 0, 9'h1A0, 32'h200, 5'd1, 5'd0, 5'd0), "t3_lw0");
        step(mk(0, 0, 9'h10C, 32'h204, 5'd0, 5'd0, 5'd3), "t3_r0");
        chk("t3_valid", 64'(ifa.valid_o), 64'd1);

        // Stall with an active hazard: hold three cycles, then one bubble
        step(mk(0, 0, 9'h1A0, 32'h300, 5'd2, 5'd8, 5'd0), "t4_lw");
        for (int k = 0; k < 3; k++) begin
            step(mk(1, 0, 9'($urandom), $urandom, 5'd8, 5'd4, 5'd5), "t4_stall");
            chk("t4_haz_held", 64'(ifa.hazard_o), 64'd1);
            chk("t4_addr_held", 64'(ifa.addr_o), 64'h300);
        end
        chk("t4_scnt3", 64'(ifa.stall_cnt_o), 64'd3);
        chk("t4_bcnt", 64'(ifa.bubble_cnt_o), 64'd1);
        step(mk(0, 0, 9'h10C, 32'h304, 5'd8, 5'd4, 5'd5), "t4_release");
        chk("t4_bcnt2", 64'(ifa.bubble_cnt_o), 64'd2);

        // Flush beats stall
        step(mk(1, 1, 9'h1FF, 32'h400, 5'd1, 5'd2, 5'd3), "t5_flush");
        chk("t5_ctrl0", 64'(ifa.ctrl_o), 64'd0);
        chk("t5_bcnt3", 64'(ifa.bubble_cnt_o), 64'd3);
        chk("t5_scnt3", 64'(ifa.stall_cnt_o), 64'd3);

        // Saturation on the 2-bit counters of DUT B
        do_reset("t6_rst");
        for (int k = 1; k <= 5; k++) begin
            step(mk(1, 0, 9'h0, 32'h0, 5'd0, 5'd0, 5'd0), "t6_stall");
            chk("t6_bscnt", 64'(ifb.stall_cnt_o), 64'((k < 3) ? k : 3));
        end

        // Randomised traffic with occasional mid-run resets
        for (int n = 0; n < 400; n++) begin
            i = mk(($urandom % 5) == 0, ($urandom % 8) == 0, 9'($urandom), $urandom,
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom));
            if (($urandom % 3) == 0) i.c[5] = 1'b1;
            step(i, "rnd");
            if (($urandom % 60) == 0) do_reset("rnd_rst");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

`default_nettype wire
